// File: rtl/adc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_pkg : constants shared by the ADC128S-style SPI slave model     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package adc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CH_SEL_MSB = 13;
  localparam int CH_SEL_LSB = 11;

  localparam logic [2:0] CH_LD_LFT  = 3'd0;
  localparam logic [2:0] CH_LD_RGHT = 3'd4;
  localparam logic [2:0] CH_STEER   = 3'd5;
  localparam logic [2:0] CH_BATT    = 3'd6;

  localparam logic [4:0] BIT_CNT_FULL = 5'(FRAME_BITS);

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_edge_sync : double-flop sync of SS_n/SCLK/MOSI plus edge pulses |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module spi_edge_sync
  import adc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n_in,
  input  logic sclk_in,
  input  logic mosi_in,
  output logic ss_n_sync,
  output logic mosi_sync,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise
);

  logic [2:0] ss_q, ss_d;
  logic [2:0] sclk_q, sclk_d;
  logic [1:0] mosi_q, mosi_d;

  always_comb begin
    ss_d   = {ss_q[1:0], ss_n_in};
    sclk_d = {sclk_q[1:0], sclk_in};
    mosi_d = {mosi_q[0], mosi_in};
  end

  // Idle bus state on reset so no spurious edge follows reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= ss_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end

  assign ss_n_sync = ss_q[1];
  assign mosi_sync = mosi_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];

endmodule
`default_nettype wire

// File: rtl/adc128s_fc_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc128s_fc_model : 8-ch 12-bit SPI A2D slave, pipelined channel sel |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module adc128s_fc_model
  import adc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic ss_n_sync, mosi_sync, sclk_rise, sclk_fall, ss_fall, ss_rise;

  spi_edge_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n_in   (SS_n),
    .sclk_in   (SCLK),
    .mosi_in   (MOSI),
    .ss_n_sync (ss_n_sync),
    .mosi_sync (mosi_sync),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise)
  );

  logic [2:0]            chnl_q, chnl_d;
  logic [FRAME_BITS-1:0] tx_shft_q, tx_shft_d;
  logic [FRAME_BITS-1:0] rx_shft_q, rx_shft_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [11:0]           sample;

  always_comb begin
    sample = 12'h000;
    case (chnl_q)
      CH_LD_LFT:  sample = ld_cell_lft;
      CH_LD_RGHT: sample = ld_cell_rght;
      CH_STEER:   sample = steerPot;
      CH_BATT:    sample = batt;
      default:    sample = 12'h000;
    endcase
  end

  always_comb begin
    chnl_d    = chnl_q;
    tx_shft_d = tx_shft_q;
    rx_shft_d = rx_shft_q;
    bit_cnt_d = bit_cnt_q;

    if (sclk_rise && !ss_n_sync) begin
      rx_shft_d = (rx_shft_q << 1) | {{(FRAME_BITS-1){1'b0}}, mosi_sync};
      if (bit_cnt_q != BIT_CNT_FULL)
        bit_cnt_d = bit_cnt_q + 5'd1;
    end

    if (ss_fall) begin
      tx_shft_d = {4'h0, sample};
      bit_cnt_d = 5'd0;
    end else if (sclk_fall && !ss_n_sync) begin
      tx_shft_d = tx_shft_q << 1;
    end

    // Short or over-long frames leave the channel selection untouched.
    if (ss_rise && (bit_cnt_q == BIT_CNT_FULL))
      chnl_d = rx_shft_q[CH_SEL_MSB:CH_SEL_LSB];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chnl_q    <= 3'd0;
      tx_shft_q <= '0;
      rx_shft_q <= '0;
      bit_cnt_q <= 5'd0;
    end else begin
      chnl_q    <= chnl_d;
      tx_shft_q <= tx_shft_d;
      rx_shft_q <= rx_shft_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign MISO = tx_shft_q[FRAME_BITS-1] & ~ss_n_sync;

endmodule
`default_nettype wire

// File: tb/tb_adc128s_fc_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_adc128s_fc_model : directed SPI frames against a channel model   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_adc128s_fc_model;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] ld_cell_lft, ld_cell_rght, steerPot, batt;

  adc128s_fc_model dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;
  logic exp_bit = 1'b0;
  int   m_chnl  = 0;

  // Per-cycle MISO check while the bench declares the line stable.
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (MISO !== exp_bit) begin
        n_fail++;
        $display("FAIL miso_bit @%0t: got %b, expected %b", $time, MISO, exp_bit);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input int ch);
    case (ch)
      0:       return {4'h0, ld_cell_lft};
      4:       return {4'h0, ld_cell_rght};
      5:       return {4'h0, steerPot};
      6:       return {4'h0, batt};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                       input logic [11:0] chg_val, output logic [15:0] got);
    logic [15:0] exp;
    exp = model_word(m_chnl);
    got = 16'h0000;
    SS_n = 1'b0;
    MOSI = cmd[15];
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) batt = chg_val;
      exp_bit = exp[15-i];
      chk_en  = 1'b1;
      got[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(5);
      chk_en = 1'b0;
      SCLK   = 1'b0;
      if (i < 15) MOSI = cmd[14-i];
      wait_clk(5);
    end
    SS_n = 1'b1;
    wait_clk(5);
    exp_bit = 1'b0;
    chk_en  = 1'b1;
    wait_clk(2);
    chk_en = 1'b0;
    if (nbits == 16) m_chnl = int'(cmd[13:11]);
  endtask

  logic [15:0] got;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    ld_cell_lft = 12'h356; ld_cell_rght = 12'h356; steerPot = 12'h200; batt = 12'h900;
    wait_clk(3);
    check16("reset_miso", {15'h0, MISO}, 16'h0000);
    rst_n = 1'b1;
    wait_clk(3);

    frame(16'h0000, 16, -1, 12'h0, got); check16("f1_ch0_after_reset", got, 16'h0356);
    ld_cell_lft = 12'h123;
    frame(16'h2000, 16, -1, 12'h0, got); check16("f2_ch0", got, 16'h0123);
    frame(16'h3000, 16, -1, 12'h0, got); check16("f3_ch4", got, 16'h0356);
    frame(16'h2800, 16, -1, 12'h0, got); check16("f4_ch6", got, 16'h0900);
    frame(16'h0800, 16, -1, 12'h0, got); check16("f5_ch5", got, 16'h0200);
    frame(16'h2000, 16, -1, 12'h0, got); check16("f6_ch1", got, 16'h0000);
    frame(16'h3000, 8,  -1, 12'h0, got); check16("f7_abort_ch4", got, 16'h0300);

    // SCLK activity with SS_n high must not disturb anything.
    MOSI = 1'b1;
    repeat (3) begin SCLK = 1'b1; wait_clk(5); SCLK = 1'b0; wait_clk(5); end

    frame(16'h3000, 16, -1, 12'h0,   got); check16("f8_chnl_kept", got, 16'h0356);
    frame(16'h3000, 16,  4, 12'hABC, got); check16("f9_batt_latched", got, 16'h0900);
    frame(16'h3000, 16, -1, 12'h0,   got); check16("f10_batt_new", got, 16'h0ABC);

    // Mid-frame reset: four bits into 0x0ABC, MISO shows bit 11 (=1).
    SS_n = 1'b0; MOSI = 1'b0;
    wait_clk(5);
    repeat (4) begin SCLK = 1'b1; wait_clk(5); SCLK = 1'b0; wait_clk(5); end
    check16("pre_reset_miso", {15'h0, MISO}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check16("mid_reset_miso", {15'h0, MISO}, 16'h0000);
    SS_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    m_chnl = 0;
    wait_clk(3);

    frame(16'h3000, 16, -1, 12'h0, got); check16("f12_ch0_after_rst", got, 16'h0123);
    frame(16'h0000, 16, -1, 12'h0, got); check16("f13_ch6", got, 16'h0ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
